button_conditioner: RTL and testbench



---
 rtl/button_conditioner.sv | 208 ++++++++++++++++++++
 tb/tb_button_conditioner.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and edge-detect push buttons.
// Optional auto-repeat on held buttons is built when BTN_AUTOREPEAT_EN is defined.

module button_conditioner #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 512,
    parameter int REPEAT_DELAY    = 5_000_000,
    parameter int REPEAT_PERIOD   = 2_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_CHK,
        ST_HELD,
        ST_REL_CHK
    } state_t;

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LIM  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam bit DB_ONE = (DEBOUNCE_CYCLES <= 1);

    if ((DEBOUNCE_CYCLES < 1) || (REPEAT_DELAY < 1) ||
        (REPEAT_PERIOD < 1) || (NUM_BTN < 1)) begin : g_bad_params
        $error("button_conditioner: parameters must be >= 1");
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                             REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] RPT_DLY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_PER = RW'(REPEAT_PERIOD);
    localparam logic [RW-1:0] RPT_ONE = RW'(1);
`endif

    logic [NUM_BTN-1:0] r_sync1;
    logic [NUM_BTN-1:0] r_sync2;

    // Two-flop synchroniser for the asynchronous button pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        state_t        r_state;
        state_t        w_state_nxt;
        logic [CW-1:0] r_cnt;
        logic [CW-1:0] w_cnt_nxt;
        logic [CW-1:0] w_cnt_inc;
        logic          r_level;
        logic          w_level_nxt;
        logic          r_press;
        logic          w_press_nxt;
        logic          r_rel;
        logic          w_rel_nxt;
        logic          w_held_entry;
        logic          w_s;
`ifdef BTN_AUTOREPEAT_EN
        logic [RW-1:0] r_rpt;
        logic [RW-1:0] w_rpt_nxt;
        logic [RW-1:0] w_rpt_inc;
        logic [RW-1:0] w_rpt_tgt;
        logic          r_rpt_seen;
        logic          w_rpt_seen_nxt;
`endif

        assign w_s       = r_sync2[g];
        assign w_cnt_inc = (r_cnt == DB_LIM) ? r_cnt : r_cnt + CNT_ONE;

        // Debounce next-state, stable counter and event pulses
        always_comb begin
            w_state_nxt  = r_state;
            w_cnt_nxt    = r_cnt;
            w_level_nxt  = r_level;
            w_press_nxt  = 1'b0;
            w_rel_nxt    = 1'b0;
            w_held_entry = 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt = '0;
                    if (w_s) begin
                        if (DB_ONE) begin
                            w_state_nxt  = ST_HELD;
                            w_level_nxt  = 1'b1;
                            w_press_nxt  = 1'b1;
                            w_held_entry = 1'b1;
                        end else begin
                            w_state_nxt = ST_PRESS_CHK;
                            w_cnt_nxt   = CNT_ONE;
                        end
                    end
                end
                ST_PRESS_CHK: begin
                    if (!w_s) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_inc >= DB_LIM) begin
                        w_state_nxt  = ST_HELD;
                        w_cnt_nxt    = '0;
                        w_level_nxt  = 1'b1;
                        w_press_nxt  = 1'b1;
                        w_held_entry = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_HELD: begin
                    w_cnt_nxt = '0;
                    if (!w_s) begin
                        if (DB_ONE) begin
                            w_state_nxt = ST_IDLE;
                            w_level_nxt = 1'b0;
                            w_rel_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = ST_REL_CHK;
                            w_cnt_nxt   = CNT_ONE;
                        end
                    end
                end
                ST_REL_CHK: begin
                    if (w_s) begin
                        w_state_nxt = ST_HELD;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_inc >= DB_LIM) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_level_nxt = 1'b0;
                        w_rel_nxt   = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                end
            endcase
`ifdef BTN_AUTOREPEAT_EN
            w_rpt_nxt      = r_rpt;
            w_rpt_seen_nxt = r_rpt_seen;
            w_rpt_inc      = r_rpt + RPT_ONE;
            w_rpt_tgt      = r_rpt_seen ? RPT_PER : RPT_DLY;
            if (w_held_entry || (r_state == ST_IDLE)) begin
                w_rpt_nxt      = '0;
                w_rpt_seen_nxt = 1'b0;
            end else if ((r_state == ST_HELD) && w_s) begin
                if (w_rpt_inc >= w_rpt_tgt) begin
                    w_rpt_nxt      = '0;
                    w_rpt_seen_nxt = 1'b1;
                    w_press_nxt    = 1'b1;
                end else begin
                    w_rpt_nxt = w_rpt_inc;
                end
            end
`endif
        end

        // Debounce state, counter and registered outputs
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_press <= 1'b0;
                r_rel   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_level <= w_level_nxt;
                r_press <= w_press_nxt;
                r_rel   <= w_rel_nxt;
            end
        end

`ifdef BTN_AUTOREPEAT_EN
        // Repeat timer, frozen while a release is being checked
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rpt      <= '0;
                r_rpt_seen <= 1'b0;
            end else begin
                r_rpt      <= w_rpt_nxt;
                r_rpt_seen <= w_rpt_seen_nxt;
            end
        end
`endif

        assign btn_level[g]   = r_level;
        assign btn_press[g]   = r_press;
        assign btn_release[g] = r_rel;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench for button_conditioner.
// Repeat expectations follow BTN_AUTOREPEAT_EN when it is defined.

module tb_button_conditioner;

    localparam int NB = 4;
    localparam int DB = 8;
    localparam int RD = 40;
    localparam int RP = 10;

    typedef struct {
        int         cyc;
        logic [3:0] pr;
        logic [3:0] rl;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [NB-1:0] btn_raw = '0;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    ev_t        sb[$];
    logic [3:0] exp_pr;
    logic [3:0] exp_rl;
    logic [3:0] exp_lvl = '0;

    button_conditioner #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_ev(input int c, input logic [3:0] pr,
                           input logic [3:0] rl);
        ev_t e;
        e.cyc = c;
        e.pr  = pr;
        e.rl  = rl;
        sb.push_back(e);
    endtask

    // Press pulse at p, plus repeats on every held edge before leave.
    task automatic push_press(input logic [3:0] m, input int p,
                              input int leave);
        push_ev(p, m, 4'b0000);
`ifdef BTN_AUTOREPEAT_EN
        for (int t = p + RD; t < leave; t += RP) push_ev(t, m, 4'b0000);
`else
        if (leave < p) $display("note: leave before press");
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (btn_level !== 4'b0 || btn_press !== 4'b0 ||
            btn_release !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_async lvl=%b pr=%b rl=%b need 0",
                     btn_level, btn_press, btn_release);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (btn_level !== 4'b0 || btn_press !== 4'b0 ||
            btn_release !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_hold lvl=%b pr=%b rl=%b need 0",
                     btn_level, btn_press, btn_release);
        end
        rst_n = 1'b1;
        exp_lvl = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (btn_level !== 4'b0 || btn_press !== 4'b0 ||
                btn_release !== 4'b0) begin
                n_fail++;
                $display("FAIL reset_after lvl=%b pr=%b rl=%b need 0",
                         btn_level, btn_press, btn_release);
            end
        end
    endtask

    task automatic test_clean_press();
        int c0;
        @(negedge clk);
        c0 = cyc;
        btn_raw[0] = 1'b1;
        push_press(4'b0001, c0 + DB + 2, c0 + 103);
        for (int k = 0; k < 125; k++) begin
            @(negedge clk);
            exp_pr = '0;
            exp_rl = '0;
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                exp_pr = sb[0].pr;
                exp_rl = sb[0].rl;
                void'(sb.pop_front());
                exp_lvl = (exp_lvl | exp_pr) & ~exp_rl;
            end
            n_checks++;
            if (btn_press !== exp_pr || btn_release !== exp_rl ||
                btn_level !== exp_lvl) begin
                n_fail++;
                $display("FAIL clean c=%0d pr=%b rl=%b lvl=%b need %b %b %b",
                         cyc - c0, btn_press, btn_release, btn_level,
                         exp_pr, exp_rl, exp_lvl);
            end
            if (cyc == c0 + 100) begin
                btn_raw[0] = 1'b0;
                push_ev(c0 + 101 + DB + 1, 4'b0000, 4'b0001);
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL clean_pending left=%0d need 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_bounce();
        int c0;
        @(negedge clk);
        c0 = cyc;
        btn_raw[1] = 1'b1;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            n_checks++;
            if (btn_press !== 4'b0 || btn_release !== 4'b0 ||
                btn_level !== 4'b0) begin
                n_fail++;
                $display("FAIL bounce c=%0d pr=%b rl=%b lvl=%b need 0",
                         cyc - c0, btn_press, btn_release, btn_level);
            end
            btn_raw[1] = ((cyc - c0) < 70) && (((cyc - c0) % 7) < 5);
        end
    endtask

    task automatic test_glitch();
        int c0;
        @(negedge clk);
        c0 = cyc;
        btn_raw[1] = 1'b1;
        push_press(4'b0010, c0 + 18, c0 + 33);
        for (int k = 0; k < 55; k++) begin
            @(negedge clk);
            exp_pr = '0;
            exp_rl = '0;
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                exp_pr = sb[0].pr;
                exp_rl = sb[0].rl;
                void'(sb.pop_front());
                exp_lvl = (exp_lvl | exp_pr) & ~exp_rl;
            end
            n_checks++;
            if (btn_press !== exp_pr || btn_release !== exp_rl ||
                btn_level !== exp_lvl) begin
                n_fail++;
                $display("FAIL glitch c=%0d pr=%b rl=%b lvl=%b need %b %b %b",
                         cyc - c0, btn_press, btn_release, btn_level,
                         exp_pr, exp_rl, exp_lvl);
            end
            if (cyc == c0 + 7 || cyc == c0 + 25) btn_raw[1] = 1'b0;
            if (cyc == c0 + 8 || cyc == c0 + 26) btn_raw[1] = 1'b1;
            if (cyc == c0 + 30) begin
                btn_raw[1] = 1'b0;
                push_ev(c0 + 40, 4'b0000, 4'b0010);
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_pending left=%0d need 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_simultaneous();
        int c0;
        @(negedge clk);
        c0 = cyc;
        btn_raw[3:2] = 2'b11;
        push_press(4'b1100, c0 + 10, c0 + 23);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            exp_pr = '0;
            exp_rl = '0;
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                exp_pr = sb[0].pr;
                exp_rl = sb[0].rl;
                void'(sb.pop_front());
                exp_lvl = (exp_lvl | exp_pr) & ~exp_rl;
            end
            n_checks++;
            if (btn_press !== exp_pr || btn_release !== exp_rl ||
                btn_level !== exp_lvl) begin
                n_fail++;
                $display("FAIL simul c=%0d pr=%b rl=%b lvl=%b need %b %b %b",
                         cyc - c0, btn_press, btn_release, btn_level,
                         exp_pr, exp_rl, exp_lvl);
            end
            if (cyc == c0 + 20) begin
                btn_raw[3:2] = 2'b00;
                push_ev(c0 + 30, 4'b0000, 4'b1100);
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL simul_pending left=%0d need 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_autorepeat();
        int c0;
        @(negedge clk);
        c0 = cyc;
        btn_raw[0] = 1'b1;
        push_press(4'b0001, c0 + 10, c0 + 93);
        for (int k = 0; k < 125; k++) begin
            @(negedge clk);
            exp_pr = '0;
            exp_rl = '0;
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                exp_pr = sb[0].pr;
                exp_rl = sb[0].rl;
                void'(sb.pop_front());
                exp_lvl = (exp_lvl | exp_pr) & ~exp_rl;
            end
            n_checks++;
            if (btn_press !== exp_pr || btn_release !== exp_rl ||
                btn_level !== exp_lvl) begin
                n_fail++;
                $display("FAIL repeat c=%0d pr=%b rl=%b lvl=%b need %b %b %b",
                         cyc - c0, btn_press, btn_release, btn_level,
                         exp_pr, exp_rl, exp_lvl);
            end
            if (cyc == c0 + 90) begin
                btn_raw[0] = 1'b0;
                push_ev(c0 + 100, 4'b0000, 4'b0001);
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL repeat_pending left=%0d need 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        @(negedge clk);
        c0 = cyc;
        btn_raw[3] = 1'b1;
        push_press(4'b1000, c0 + 10, c0 + 27);
        for (int k = 0; k < 75; k++) begin
            @(negedge clk);
            exp_pr = '0;
            exp_rl = '0;
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                exp_pr = sb[0].pr;
                exp_rl = sb[0].rl;
                void'(sb.pop_front());
                exp_lvl = (exp_lvl | exp_pr) & ~exp_rl;
            end
            n_checks++;
            if (btn_press !== exp_pr || btn_release !== exp_rl ||
                btn_level !== exp_lvl) begin
                n_fail++;
                $display("FAIL rstmid c=%0d pr=%b rl=%b lvl=%b need %b %b %b",
                         cyc - c0, btn_press, btn_release, btn_level,
                         exp_pr, exp_rl, exp_lvl);
            end
            if (cyc == c0 + 20) btn_raw[0] = 1'b1;
            if (cyc == c0 + 27) begin
                rst_n = 1'b0;
                exp_lvl = '0;
                #1;
                n_checks++;
                if (btn_level !== 4'b0 || btn_press !== 4'b0 ||
                    btn_release !== 4'b0) begin
                    n_fail++;
                    $display("FAIL rstmid_async lvl=%b pr=%b rl=%b need 0",
                             btn_level, btn_press, btn_release);
                end
            end
            if (cyc == c0 + 30) begin
                rst_n = 1'b1;
                push_press(4'b1001, c0 + 40, c0 + 53);
            end
            if (cyc == c0 + 50) begin
                btn_raw[0] = 1'b0;
                btn_raw[3] = 1'b0;
                push_ev(c0 + 60, 4'b0000, 4'b1001);
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_pending left=%0d need 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_autorepeat();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
